// File: rtl/show2c_bcd_seq.sv
// rtl/show2c_bcd_seq.sv - sequential signed/unsigned binary to packed BCD converter (double dabble)
module show2c_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 16 || DIGITS < 1 || (64'd10 ** DIGITS) < (64'd1 << WIDTH)) begin : g_param_check
        $error("show2c_bcd_seq: WIDTH must be 2..16 and 10**DIGITS >= 2**WIDTH");
    end

    typedef enum logic {S_IDLE, S_CONVERT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] w_neg;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   w_adj;
    logic [AW-1:0]   w_shift;
    logic [AW-1:0]   r_bcd;
    logic [CW-1:0]   r_cnt;
    logic            r_pend;
    logic            r_sign;
    logic            r_done;
    logic            w_accept;
    logic            w_last;
    logic            w_neg_in;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_CONVERT;
                    w_accept = 1'b1;
                end
            end
            S_CONVERT: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_IDLE;
                    w_last = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // All nibbles are corrected in parallel before the shift.
    always_comb begin
        w_adj = r_acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_acc[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
        end
    end

    assign w_shift  = {w_adj[AW-2:0], r_mag[WIDTH-1]};
    assign w_neg    = ~din + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_neg_in = signed_mode & din[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mag  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_bcd  <= '0;
            r_sign <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mag  <= w_neg_in ? w_neg : din;
                r_pend <= w_neg_in;
                r_acc  <= '0;
                r_cnt  <= CW'(WIDTH);
            end else if (r_state == S_CONVERT) begin
                r_acc <= w_shift;
                r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt - CW'(1);
                // Outputs only move on the final iteration so partial sums never show.
                if (w_last) begin
                    r_bcd  <= w_shift;
                    r_sign <= r_pend;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == S_CONVERT);
    assign done = r_done;
    assign sign = r_sign;
    assign bcd  = r_bcd;

endmodule

// File: tb/tb_show2c_bcd_seq.sv
// tb/tb_show2c_bcd_seq.sv - self-checking bench for show2c_bcd_seq at WIDTH=8 and WIDTH=12
module tb_show2c_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n, start, sm;
    logic [7:0]  din8;
    logic [11:0] din12;
    logic        busy8, done8, sign8, busy12, done12, sign12;
    logic [15:0] bcd8, bcd12;

    always #5 clk = ~clk;

    show2c_bcd_seq #(.WIDTH(8), .DIGITS(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .din(din8),
        .busy(busy8), .done(done8), .sign(sign8), .bcd(bcd8)
    );

    show2c_bcd_seq #(.WIDTH(12), .DIGITS(4)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .din(din12),
        .busy(busy12), .done(done12), .sign(sign12), .bcd(bcd12)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] ref_conv(input int w, input logic s, input logic [15:0] d);
        int          v;
        logic        neg;
        logic [15:0] b;
        neg = s && d[w-1];
        v   = neg ? ((1 << w) - int'(d)) : int'(d);
        for (int k = 0; k < 4; k++) begin
            b[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {neg, b};
    endfunction

    // Reference model: tracks acceptance, queues the expected result, retires it after WIDTH edges.
    typedef struct packed {logic s; logic [15:0] b;} res_t;
    res_t        q8[$];
    res_t        q12[$];
    res_t        r8, r12;
    int          cnt8 = 0, cnt12 = 0;
    logic        ed8 = 0, es8 = 0, ed12 = 0, es12 = 0;
    logic [15:0] eb8 = 0, eb12 = 0;
    logic        mvalid = 0;

    always @(posedge clk) begin
        mvalid = 1'b1;
        if (!rst_n) begin
            cnt8 = 0; cnt12 = 0;
            q8.delete(); q12.delete();
            ed8 = 0; es8 = 0; eb8 = 0;
            ed12 = 0; es12 = 0; eb12 = 0;
        end else begin
            ed8  = 0;
            ed12 = 0;
            if (cnt8 > 0) begin
                cnt8--;
                if (cnt8 == 0 && q8.size() > 0) begin
                    r8 = q8.pop_front(); es8 = r8.s; eb8 = r8.b; ed8 = 1;
                end
            end else if (start) begin
                q8.push_back(ref_conv(8, sm, {8'h00, din8}));
                cnt8 = 8;
            end
            if (cnt12 > 0) begin
                cnt12--;
                if (cnt12 == 0 && q12.size() > 0) begin
                    r12 = q12.pop_front(); es12 = r12.s; eb12 = r12.b; ed12 = 1;
                end
            end else if (start) begin
                q12.push_back(ref_conv(12, sm, {4'h0, din12}));
                cnt12 = 12;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("busy8",  busy8,  32'(cnt8 > 0));
            chk("done8",  done8,  ed8);
            chk("sign8",  sign8,  es8);
            chk("bcd8",   bcd8,   eb8);
            chk("busy12", busy12, 32'(cnt12 > 0));
            chk("done12", done12, ed12);
            chk("sign12", sign12, es12);
            chk("bcd12",  bcd12,  eb12);
        end
    end

    typedef struct {logic sm; logic [11:0] d; logic s; logic [15:0] b;} vec_t;

    task automatic run(input int w, input vec_t v);
        int lat;
        @(negedge clk);
        start = 1'b1;
        sm    = v.sm;
        if (w == 8) begin din8 = v.d[7:0]; din12 = 12'($urandom); end
        else        begin din12 = v.d;     din8  = 8'($urandom);  end
        @(negedge clk);
        start = 1'b0;
        sm    = ~v.sm;
        din8  = ~din8;
        din12 = ~din12;
        lat   = 0;
        while (!(w == 8 ? done8 : done12) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("lat%0d_%0h", w, v.d), lat, w);
        chk($sformatf("sign%0d_%0h", w, v.d), (w == 8) ? sign8 : sign12, v.s);
        chk($sformatf("bcd%0d_%0h", w, v.d), (w == 8) ? bcd8 : bcd12, v.b);
    endtask

    vec_t tbl8[7];
    vec_t tbl12[3];
    int   nd;

    initial begin
        #400000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        tbl8[0]  = '{1'b1, 12'h0FF, 1'b1, 16'h0001};
        tbl8[1]  = '{1'b1, 12'h080, 1'b1, 16'h0128};
        tbl8[2]  = '{1'b1, 12'h09B, 1'b1, 16'h0101};
        tbl8[3]  = '{1'b1, 12'h01B, 1'b0, 16'h0027};
        tbl8[4]  = '{1'b1, 12'h000, 1'b0, 16'h0000};
        tbl8[5]  = '{1'b0, 12'h0FF, 1'b0, 16'h0255};
        tbl8[6]  = '{1'b0, 12'h085, 1'b0, 16'h0133};
        tbl12[0] = '{1'b1, 12'h800, 1'b1, 16'h2048};
        tbl12[1] = '{1'b1, 12'h7FF, 1'b0, 16'h2047};
        tbl12[2] = '{1'b0, 12'hFFF, 1'b0, 16'h4095};

        rst_n = 1'b0; start = 1'b0; sm = 1'b0; din8 = 8'h00; din12 = 12'h000;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_bcd",  bcd8,  0);
        chk("rst_sign", sign8, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run(8, tbl8[i]);
        repeat (15) @(negedge clk);
        for (int i = 0; i < 3; i++) run(12, tbl12[i]);
        repeat (15) @(negedge clk);

        // start held through busy and into the done cycle: exactly two conversions.
        start = 1'b1; sm = 1'b0; din8 = 8'h05;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 1) din8 = 8'h33;
            if (k == 9) start = 1'b0;
            if (done8) begin
                nd++;
                if (nd == 1) begin
                    chk("hs_t1", k, 8);
                    chk("hs_bcd1", bcd8, 16'h0005);
                end else if (nd == 2) begin
                    chk("hs_t2", k, 17);
                    chk("hs_bcd2", bcd8, 16'h0051);
                end
            end
        end
        chk("hs_count", nd, 2);
        repeat (15) @(negedge clk);

        // Reset sampled on the 4th CONVERT edge aborts the conversion.
        start = 1'b1; sm = 1'b1; din8 = 8'hC7;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 3) rst_n = 1'b0;
            if (k == 4) begin
                rst_n = 1'b1;
                chk("abort_busy", busy8, 0);
                chk("abort_done", done8, 0);
                chk("abort_bcd",  bcd8,  0);
                chk("abort_sign", sign8, 0);
            end
            if (done8) nd++;
        end
        chk("abort_no_done", nd, 0);
        run(8, '{1'b0, 12'h003, 1'b0, 16'h0003});

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            logic [16:0] r;
            v.sm = 1'($urandom);
            v.d  = {4'h0, 8'($urandom)};
            r    = ref_conv(8, v.sm, {4'h0, v.d});
            v.s  = r[16];
            v.b  = r[15:0];
            run(8, v);
        end

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
